// File: rtl/msk_sched_pkg.sv
// Shared types and helpers for the masked chunk scheduler.
package msk_sched_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Index width that never collapses to zero bits
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/msk_vld_pipe.sv
// LAT-deep valid shift register that advances only when the gadget pipeline
// is enabled, so valid tags stay aligned with data held in frozen stages.
module msk_vld_pipe #(
   parameter int LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic din,
   output logic dout
);

   generate
      if (LAT == 1) begin : g_one
         logic q;
         // single-stage valid tag
         always_ff @(posedge clk) begin
            if (rst || clr) q <= 1'b0;
            else if (en)    q <= din;
         end
         assign dout = q;
      end else begin : g_multi
         logic [LAT-1:0] q;
         // shift new issue tag in at bit 0, oldest tag leaves at LAT-1
         always_ff @(posedge clk) begin
            if (rst || clr) q <= '0;
            else if (en)    q <= {q[LAT-2:0], din};
         end
         assign dout = q[LAT-1];
      end
   endgenerate

endmodule

// File: rtl/msk_chunk_sched.sv
// Time-shares one fixed-latency masked gadget pipeline across NCHUNK chunks.
// Handshake: rnd_ready == issue == (FEED & rnd_valid); randomness is consumed
// in exactly the cycle the pipeline advances, so shares and masks never skew.
module msk_chunk_sched
   import msk_sched_pkg::*;
#(
   parameter  int NCHUNK = 16,
   parameter  int LAT    = 4,
   localparam int CW     = clog2_min1(NCHUNK)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic          rnd_valid,
   output logic          rnd_ready,
   output logic          gadget_en,
   output logic [CW-1:0] in_sel,
   output logic          wr_en,
   output logic [CW-1:0] wr_sel
);

   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] iss_cnt;
   logic [CW-1:0] wr_cnt;
   logic          issue;
   logic          vld_tail;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FEED;
         FEED:    if (issue && (iss_cnt == LAST)) state_nxt = DRAIN;
         DRAIN:   if (wr_en && (wr_cnt == LAST)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // output decode; rnd_valid reaches gadget_en combinationally by design
   always_comb begin
      issue     = 1'b0;
      gadget_en = 1'b0;
      case (state)
         FEED: begin
            issue     = rnd_valid;
            gadget_en = rnd_valid;
         end
         DRAIN:   gadget_en = 1'b1;
         default: gadget_en = 1'b0;
      endcase
      rnd_ready = issue;
      wr_en     = gadget_en & vld_tail;
      busy      = (state != IDLE);
      done      = (state == DONE);
      in_sel    = iss_cnt;
      wr_sel    = wr_cnt;
   end

   // issue/write counters: cleared while idle, saturate at the last chunk
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE)) begin
         iss_cnt <= '0;
         wr_cnt  <= '0;
      end else begin
         if (issue && (iss_cnt != LAST)) iss_cnt <= iss_cnt + CW'(1);
         if (wr_en && (wr_cnt != LAST))  wr_cnt  <= wr_cnt + CW'(1);
      end
   end

   msk_vld_pipe #(.LAT(LAT)) u_vld (
      .clk  (clk),
      .rst  (rst),
      .clr  (state == IDLE),
      .en   (gadget_en),
      .din  (issue),
      .dout (vld_tail)
   );

endmodule
